// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-port sync RAM between
// a host (requester 0) and the compaction engine (requester 1), with per-requester read return.
module mem_port_arbiter #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    parameter int MAX_HOLD = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0,
    input  logic             i_rden0,
    input  logic             i_wren0,
    input  logic [AW-1:0]    i_addr0,
    input  logic [WIDTH-1:0] i_wdata0,
    output logic             o_gnt0,
    output logic             o_rvalid0,
    input  logic             i_req1,
    input  logic             i_rden1,
    input  logic             i_wren1,
    input  logic [AW-1:0]    i_addr1,
    input  logic [WIDTH-1:0] i_wdata1,
    output logic             o_gnt1,
    output logic             o_rvalid1,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_mem_rden,
    output logic             o_mem_wren,
    output logic [AW-1:0]    o_mem_addr,
    output logic [WIDTH-1:0] o_mem_wdata,
    input  logic [WIDTH-1:0] i_mem_rdata
);
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [1:0] state, state_nxt;
    logic [HW-1:0] hold;
    logic ptr;
    logic fwd0, fwd1, rd0, rd1, hold_done;

    assign o_gnt0 = state == OWN0;
    assign o_gnt1 = state == OWN1;
    assign fwd0 = o_gnt0 & i_req0;
    assign fwd1 = o_gnt1 & i_req1;
    // a write strobe wins over a simultaneous read strobe
    assign rd0 = fwd0 & i_rden0 & ~i_wren0;
    assign rd1 = fwd1 & i_rden1 & ~i_wren1;
    assign o_mem_wren = (fwd0 & i_wren0) | (fwd1 & i_wren1);
    assign o_mem_rden = rd0 | rd1;
    assign o_mem_addr = fwd0 ? i_addr0 : fwd1 ? i_addr1 : '0;
    assign o_mem_wdata = fwd0 ? i_wdata0 : fwd1 ? i_wdata1 : '0;
    assign o_rdata = i_mem_rdata;
    assign hold_done = hold == HOLD_LAST;

    always_comb begin
        state_nxt = state;
        case (state)
            OWN0: state_nxt = !i_req0 ? (i_req1 ? OWN1 : IDLE) : (hold_done && i_req1) ? OWN1 : OWN0;
            OWN1: state_nxt = !i_req1 ? (i_req0 ? OWN0 : IDLE) : (hold_done && i_req0) ? OWN0 : OWN1;
            default: state_nxt = (i_req0 && i_req1) ? (ptr ? OWN1 : OWN0) :
                                 i_req0 ? OWN0 : i_req1 ? OWN1 : IDLE;
        endcase
    end

    // ptr high favours requester 1; the registered valids act as the one-hot read tag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            ptr       <= 1'b0;
            o_rvalid0 <= 1'b0;
            o_rvalid1 <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold      <= (state_nxt != state) ? '0 : (state != IDLE && !hold_done) ? hold + 1'b1 : hold;
            if (state != IDLE && state_nxt != state)
                ptr <= state == OWN0;
            o_rvalid0 <= rd0;
            o_rvalid1 <= rd1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus against an ownership/queue-level model of the arbiter,
// checked every cycle, plus hand-computed literal expectations.
module tb_mem_port_arbiter;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic req0, rden0, wren0, req1, rden1, wren1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic mem_rden, mem_wren;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] ram_q = 8'h00;
    logic [7:0] ram [32];
    logic ram_seeded = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DEPTH(32), .WIDTH(8), .MAX_HOLD(MH)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_rden0(rden0), .i_wren0(wren0), .i_addr0(addr0), .i_wdata0(wdata0),
        .o_gnt0(gnt0), .o_rvalid0(rvalid0),
        .i_req1(req1), .i_rden1(rden1), .i_wren1(wren1), .i_addr1(addr1), .i_wdata1(wdata1),
        .o_gnt1(gnt1), .o_rvalid1(rvalid1),
        .o_rdata(rdata), .o_mem_rden(mem_rden), .o_mem_wren(mem_wren),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(ram_q)
    );

    function automatic logic [7:0] seed(int i);
        return (i == 5) ? 8'h17 : 8'(i * 3 + 1);
    endfunction

    always @(posedge clk) begin
        if (!ram_seeded) begin
            for (int i = 0; i < 32; i++) ram[i] <= seed(i);
            ram_seeded <= 1'b1;
        end else begin
            if (mem_wren) ram[mem_addr] <= mem_wdata;
            if (mem_rden) ram_q <= ram[mem_addr];
        end
    end

    // model: owner is -1/0/1, run counts owned cycles without limit, fav is who wins a tie
    int m_owner, m_run, m_fav, m_next;
    logic m_rv0, m_rv1, m_seeded = 1'b0;
    logic [7:0] m_rdata;
    logic [7:0] model_mem [32];
    logic e_f0, e_f1, e_rd0, e_rd1, e_wr;
    logic [4:0] e_addr;
    logic [7:0] e_wdata;

    function automatic int arb(int own, int run, int fav, logic r0, logic r1);
        logic mine, theirs;
        if (own < 0) return (r0 && r1) ? fav : r0 ? 0 : r1 ? 1 : -1;
        mine = (own == 0) ? r0 : r1;
        theirs = (own == 0) ? r1 : r0;
        if (!mine) return theirs ? 1 - own : -1;
        if (theirs && run >= MH) return 1 - own;
        return own;
    endfunction

    assign m_next = arb(m_owner, m_run, m_fav, req0, req1);
    assign e_f0 = (m_owner == 0) && req0;
    assign e_f1 = (m_owner == 1) && req1;
    assign e_rd0 = e_f0 && rden0 && !wren0;
    assign e_rd1 = e_f1 && rden1 && !wren1;
    assign e_wr = (e_f0 && wren0) || (e_f1 && wren1);
    assign e_addr = e_f0 ? addr0 : e_f1 ? addr1 : 5'd0;
    assign e_wdata = e_f0 ? wdata0 : e_f1 ? wdata1 : 8'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_run <= 0;
            m_fav <= 0;
            m_rv0 <= 1'b0;
            m_rv1 <= 1'b0;
            if (!m_seeded) begin
                for (int i = 0; i < 32; i++) model_mem[i] <= seed(i);
                m_seeded <= 1'b1;
            end
        end else begin
            m_owner <= m_next;
            m_run <= (m_next != m_owner) ? 1 : m_run + 1;
            if (m_owner >= 0 && m_next != m_owner) m_fav <= 1 - m_owner;
            m_rv0 <= e_rd0;
            m_rv1 <= e_rd1;
            if (e_rd0) m_rdata <= model_mem[addr0];
            if (e_rd1) m_rdata <= model_mem[addr1];
            if (e_f0 && wren0) model_mem[addr0] <= wdata0;
            if (e_f1 && wren1) model_mem[addr1] <= wdata1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("gnt0", gnt0, m_owner == 0);
        chk("gnt1", gnt1, m_owner == 1);
        chk("rvalid0", rvalid0, m_rv0);
        chk("rvalid1", rvalid1, m_rv1);
        chk("mem_wren", mem_wren, e_wr);
        chk("mem_rden", mem_rden, e_rd0 || e_rd1);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("rdata_pass", rdata, ram_q);
        if (m_rv0 || m_rv1) chk("rdata", rdata, m_rdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {req0, rden0, wren0, req1, rden1, wren1} = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_gnt0", gnt0, 0);
        chk("reset_gnt1", gnt1, 0);
        chk("reset_rvalid1", rvalid1, 0);
        chk("reset_mem_addr", mem_addr, 0);

        req1 = 1'b1;
        step();
        chk("t1_gnt1", gnt1, 1);
        chk("t1_gnt0", gnt0, 0);
        rden1 = 1'b1; addr1 = 5'd5;
        #1;
        chk("t1_mem_rden", mem_rden, 1);
        chk("t1_mem_addr", mem_addr, 5);
        step();
        rden1 = 1'b0;
        chk("t1_rvalid1", rvalid1, 1);
        chk("t1_rdata", rdata, 8'h17);
        chk("t1_rvalid0", rvalid0, 0);
        req1 = 1'b0;
        step();

        req0 = 1'b1; req1 = 1'b1;
        step();
        chk("t2_first_gnt0", gnt0, 1);
        step(); step();
        req0 = 1'b0;
        step();
        chk("t2_handoff_gnt1", gnt1, 1);
        chk("t2_handoff_gnt0", gnt0, 0);
        req1 = 1'b0;
        step();
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        step();
        req0 = 1'b1; req1 = 1'b1;
        step();
        chk("t2_rr_gnt1", gnt1, 1);
        chk("t2_rr_gnt0", gnt0, 0);

        req0 = 1'b0; req1 = 1'b0;
        step();
        req1 = 1'b1;
        step();
        chk("t3_c1_gnt1", gnt1, 1);
        step();
        req0 = 1'b1;
        step(); step();
        chk("t3_c4_gnt1", gnt1, 1);
        step();
        chk("t3_forced_gnt1", gnt1, 0);
        chk("t3_forced_gnt0", gnt0, 1);

        rden0 = 1'b1; wren0 = 1'b1; addr0 = 5'd3; wdata0 = 8'hA5;
        #1;
        chk("t4_mem_wren", mem_wren, 1);
        chk("t4_mem_rden", mem_rden, 0);
        chk("t4_mem_wdata", mem_wdata, 8'hA5);
        step();
        wren0 = 1'b0;
        step();
        rden0 = 1'b0;
        chk("t4_rvalid0", rvalid0, 1);
        chk("t4_rdata", rdata, 8'hA5);
        req0 = 1'b0; req1 = 1'b0;
        step();

        req1 = 1'b1;
        step();
        req0 = 1'b1;
        step(); step(); step();
        rden1 = 1'b1; addr1 = 5'd5;
        wren0 = 1'b1; addr0 = 5'd7; wdata0 = 8'h55;
        #1;
        chk("t5_mem_wren", mem_wren, 0);
        chk("t5_mem_rden", mem_rden, 1);
        chk("t5_mem_addr", mem_addr, 5);
        step();
        wren0 = 1'b0; rden1 = 1'b0;
        chk("t5_gnt0", gnt0, 1);
        chk("t5_rvalid1", rvalid1, 1);
        chk("t5_rvalid0", rvalid0, 0);
        chk("t5_rdata", rdata, 8'h17);
        rden0 = 1'b1;
        step();
        rden0 = 1'b0;
        chk("t5_ram7_rdata", rdata, 8'h16);

        rden0 = 1'b1; addr0 = 5'd3;
        #1;
        chk("t6_pre_rden", mem_rden, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_gnt0", gnt0, 0);
        chk("t6_mem_rden", mem_rden, 0);
        chk("t6_mem_wren", mem_wren, 0);
        chk("t6_mem_addr", mem_addr, 0);
        chk("t6_rvalid0", rvalid0, 0);
        req0 = 1'b1; req1 = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("t6_stale_rvalid0", rvalid0, 0);
        step();
        chk("t6_restart_gnt0", gnt0, 1);
        chk("t6_restart_gnt1", gnt1, 0);
        chk("t6_restart_rvalid0", rvalid0, 0);
        rden0 = 1'b0; req0 = 1'b0; req1 = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
